// File: rtl/pingpong_fifo_ctrl.sv
// Ping-pong FIFO controller.
// Upstream words are written into one of two external bank FIFOs while the
// other bank, holding the previous complete frame of DEPTH words, is read out
// through a 2-entry output buffer. The banks swap once the write bank holds a
// full frame and the read bank has been fully drained.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_data/in_ready      upstream word handshake
//   out_valid/out_data/out_ready   downstream word handshake
//   fifo_wr_en, fifo_rd_en         bank write / read strobes
//   fifo_choose                    0: write fifo1, read fifo2; 1: the reverse
//   fifo1_wr_data, fifo2_wr_data   per-bank write data (0 when not selected)
//   fifo1_rd_data, fifo2_rd_data   per-bank read data, valid the cycle after a read
//   swap_pulse                     one-cycle pulse after each bank swap
module pingpong_fifo_ctrl #(
  parameter int DEPTH = 32,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          fifo_wr_en,
  output logic          fifo_rd_en,
  output logic          fifo_choose,
  output logic [DW-1:0] fifo1_wr_data,
  output logic [DW-1:0] fifo2_wr_data,
  input  logic [DW-1:0] fifo1_rd_data,
  input  logic [DW-1:0] fifo2_rd_data,
  output logic          swap_pulse
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    FILL,
    OVERLAP,
    WAIT_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  choose_q;
  logic                  swap_pulse_q;
  logic                  inflight_q;
  logic                  rd_bank_q;
  logic [1:0][DW-1:0]    obuf_q, obuf_d;
  logic [1:0]            occ_q, occ_d;

  logic                  wr_go, rd_go, pop, drained, swap, wr_full;
  logic [2:0]            pending;
  logic [DW-1:0]         rd_word;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      choose_q     <= 1'b0;
      swap_pulse_q <= 1'b0;
      inflight_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      obuf_q       <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      swap_pulse_q <= swap;
      inflight_q   <= rd_go;
      obuf_q       <= obuf_d;
      occ_q        <= occ_d;
      if (swap) begin
        choose_q <= ~choose_q;
      end
      // Remember which bank this read targets; the word returns next cycle,
      // possibly after a swap has already flipped choose_q.
      if (rd_go) begin
        rd_bank_q <= choose_q;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (swap) begin
      state_d = OVERLAP;
    end else begin
      case (state_q)
        FILL:       state_d = FILL;
        OVERLAP: begin
          if (wr_full && !drained) begin
            state_d = WAIT_DRAIN;
          end else if (drained && !wr_full) begin
            state_d = FILL;
          end
        end
        WAIT_DRAIN: state_d = WAIT_DRAIN;
        default:    state_d = FILL;
      endcase
    end
  end

  // Output / control logic
  always_comb begin
    wr_full    = (wr_cnt_q == FULL);
    in_ready   = (wr_cnt_q < FULL);
    wr_go      = in_valid && in_ready;
    pop        = (occ_q != 2'd0) && out_ready;
    drained    = (rd_cnt_q == '0) && !inflight_q;
    swap       = wr_full && drained;
    // Words that will occupy the buffer after this edge if no new read is issued
    pending    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    rd_go      = (rd_cnt_q != '0) && (pending < 3'd2);
    fifo_wr_en  = wr_go;
    fifo_rd_en  = rd_go;
    fifo_choose = choose_q;
    swap_pulse  = swap_pulse_q;
    out_valid   = (occ_q != 2'd0);
    out_data    = obuf_q[0];
    fifo1_wr_data = '0;
    fifo2_wr_data = '0;
    if (wr_go) begin
      if (choose_q) begin
        fifo2_wr_data = in_data;
      end else begin
        fifo1_wr_data = in_data;
      end
    end
  end

  // Counter and output-buffer next state
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (swap) begin
      wr_cnt_d = '0;
      rd_cnt_d = FULL;
    end else begin
      if (wr_go) begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
      if (rd_go) begin
        rd_cnt_d = rd_cnt_q - CW'(1);
      end
    end

    rd_word = rd_bank_q ? fifo1_rd_data : fifo2_rd_data;
    obuf_d  = obuf_q;
    occ_d   = occ_q;
    // Pop shifts the head out first so a same-cycle capture lands behind it.
    if (pop) begin
      obuf_d[0] = obuf_q[1];
      occ_d     = occ_q - 2'd1;
    end
    if (inflight_q) begin
      obuf_d[occ_d[0]] = rd_word;
      occ_d            = occ_d + 2'd1;
    end
  end

endmodule

// File: tb/tb_pingpong_fifo_ctrl.sv
module tb_pingpong_fifo_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          fifo_wr_en, fifo_rd_en, fifo_choose, swap_pulse;
  logic [DW-1:0] fifo1_wr_data, fifo2_wr_data;
  logic [DW-1:0] fifo1_rd_data, fifo2_rd_data;

  pingpong_fifo_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_choose(fifo_choose),
    .fifo1_wr_data(fifo1_wr_data), .fifo2_wr_data(fifo2_wr_data),
    .fifo1_rd_data(fifo1_rd_data), .fifo2_rd_data(fifo2_rd_data),
    .swap_pulse(swap_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // External bank FIFOs, reset on the same rst_n
  logic [DW-1:0] bank1[$];
  logic [DW-1:0] bank2[$];
  int bank_bad = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank1.delete();
      bank2.delete();
      fifo1_rd_data <= '0;
      fifo2_rd_data <= '0;
    end else begin
      if (fifo_wr_en) begin
        if (!fifo_choose) bank1.push_back(fifo1_wr_data);
        else              bank2.push_back(fifo2_wr_data);
        if (bank1.size() > DEPTH || bank2.size() > DEPTH) bank_bad++;
      end
      if (fifo_rd_en) begin
        if (fifo_choose) begin
          if (bank1.size() > 0) fifo1_rd_data <= bank1.pop_front();
          else bank_bad++;
        end else begin
          if (bank2.size() > 0) fifo2_rd_data <= bank2.pop_front();
          else bank_bad++;
        end
      end
    end
  end

  // Observation: accepted inputs and delivered outputs, sampled mid-cycle
  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] got_q[$];
  int swap_at[$];
  int toggles, rd_issues, low_run, max_low, wr_bad;
  logic prev_choose;

  always @(negedge clk) begin
    if (rst_n) begin
      if (swap_pulse) swap_at.push_back(acc_q.size());
      if (fifo_choose != prev_choose) toggles++;
      prev_choose = fifo_choose;
      if (fifo_rd_en) rd_issues++;
      if (!in_ready) begin
        low_run++;
        if (low_run > max_low) max_low = low_run;
      end else begin
        low_run = 0;
      end
      if (fifo_wr_en !== (in_valid && in_ready)) wr_bad++;
      if (fifo_wr_en) begin
        if (fifo1_wr_data !== (fifo_choose ? DW'(0) : in_data)) wr_bad++;
        if (fifo2_wr_data !== (fifo_choose ? in_data : DW'(0))) wr_bad++;
      end
      if (in_valid && in_ready) acc_q.push_back(in_data);
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic clear_obs();
    acc_q.delete();
    got_q.delete();
    swap_at.delete();
    toggles = 0; rd_issues = 0; low_run = 0; max_low = 0; wr_bad = 0;
    prev_choose = 1'b0;
    bank_bad = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic send_word(input logic [DW-1:0] d, output bit ok, output int cyc);
    bit acc;
    ok = 1'b0;
    cyc = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!ok && cyc < 200) begin
      acc = in_ready;
      step();
      cyc++;
      if (acc) ok = 1'b1;
    end
  endtask

  task automatic wait_out(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (got_q.size() >= n) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, fifo_rd_en, fifo_wr_en, swap_pulse, fifo_choose} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b%b want 00000", out_valid, fifo_rd_en, fifo_wr_en, swap_pulse, fifo_choose);
    end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_obs();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    bit ok; int cyc;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send_word(DW'(i), ok, cyc);
      checks++;
      if (!ok || cyc != 1) begin errors++; $display("FAIL basic_accept word %0d took %0d cycles want 1", i, cyc); end
    end
    in_valid = 1'b0;
    checks++;
    if (swap_pulse !== 1'b0) begin errors++; $display("FAIL basic_early_swap got %b want 0", swap_pulse); end
    step();
    checks++;
    if (swap_pulse !== 1'b1 || fifo_choose !== 1'b1) begin
      errors++; $display("FAIL basic_swap swap_pulse %b choose %b want 1 1", swap_pulse, fifo_choose);
    end
    step();
    checks++;
    if (swap_pulse !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_len swap_pulse %b out_valid %b want 0 0", swap_pulse, out_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
        errors++; $display("FAIL basic_out idx %0d valid %b data %0d want 1 %0d", i, out_valid, out_data, i);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_end valid %b want 0", out_valid); end
    checks++;
    if (bank_bad != 0 || wr_bad != 0) begin errors++; $display("FAIL basic_banks bank_bad %0d wr_bad %0d want 0 0", bank_bad, wr_bad); end
  endtask

  task automatic test_continuous();
    bit ok; int cyc;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      send_word(DW'(i), ok, cyc);
      checks++;
      if (!ok) begin errors++; $display("FAIL cont_send word %0d got timeout want accept", i); end
    end
    in_valid = 1'b0;
    wait_out(12, ok);
    checks++;
    if (!ok || got_q.size() != 12) begin errors++; $display("FAIL cont_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 12; i++) begin
      checks++;
      if (got_q[i] !== DW'(i + 1)) begin errors++; $display("FAIL cont_order idx %0d got %0d want %0d", i, got_q[i], i + 1); end
    end
    checks++;
    if (max_low > 2) begin errors++; $display("FAIL cont_in_ready_gap got %0d want <=2", max_low); end
    checks++;
    if (swap_at.size() != 3 || toggles != 3) begin
      errors++; $display("FAIL cont_swaps swaps %0d toggles %0d want 3 3", swap_at.size(), toggles);
    end
    for (int k = 0; k < swap_at.size(); k++) begin
      checks++;
      if (swap_at[k] != 4 * (k + 1)) begin errors++; $display("FAIL cont_swap_pos %0d got %0d want %0d", k, swap_at[k], 4 * (k + 1)); end
    end
  endtask

  task automatic test_stall();
    bit ok; int cyc;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send_word(DW'(i), ok, cyc);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_send word %0d got timeout want accept", i); end
    end
    in_data = DW'(9);
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b want 0", c, in_ready); end
    end
    checks++;
    if (fifo_rd_en !== 1'b0 || rd_issues != 2) begin
      errors++; $display("FAIL stall_reads rd_en %b issued %0d want 0 2", fifo_rd_en, rd_issues);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(1) || got_q.size() != 0) begin
      errors++; $display("FAIL stall_head valid %b data %0d popped %0d want 1 1 0", out_valid, out_data, got_q.size());
    end
    out_ready = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      send_word(DW'(i), ok, cyc);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_send word %0d got timeout want accept", i); end
    end
    in_valid = 1'b0;
    wait_out(12, ok);
    checks++;
    if (!ok || got_q.size() != 12) begin errors++; $display("FAIL stall_count got %0d want 12", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 12; i++) begin
      checks++;
      if (got_q[i] !== DW'(i + 1)) begin errors++; $display("FAIL stall_order idx %0d got %0d want %0d", i, got_q[i], i + 1); end
    end
    checks++;
    if (bank_bad != 0) begin errors++; $display("FAIL stall_banks got %0d want 0", bank_bad); end
  endtask

  task automatic test_gap();
    bit ok; int cyc;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) send_word(DW'($urandom), ok, cyc);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (swap_pulse !== 1'b0 || fifo_choose !== 1'b0) begin
        errors++; $display("FAIL gap_no_swap cycle %0d pulse %b choose %b want 0 0", c, swap_pulse, fifo_choose);
      end
    end
    for (int i = 0; i < 2; i++) send_word(DW'($urandom), ok, cyc);
    in_valid = 1'b0;
    checks++;
    if (swap_pulse !== 1'b0) begin errors++; $display("FAIL gap_early_swap got %b want 0", swap_pulse); end
    step();
    checks++;
    if (swap_pulse !== 1'b1) begin errors++; $display("FAIL gap_swap got %b want 1", swap_pulse); end
    wait_out(4, ok);
    checks++;
    if (!ok || got_q.size() != 4 || acc_q.size() != 4) begin
      errors++; $display("FAIL gap_count got %0d accepted %0d want 4 4", got_q.size(), acc_q.size());
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (got_q[i] !== acc_q[i]) begin errors++; $display("FAIL gap_order idx %0d got %0d want %0d", i, got_q[i], acc_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_word(DW'(i), ok, cyc);
    in_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (rd_issues != 2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup issued %0d valid %b want 2 1", rd_issues, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, fifo_rd_en, fifo_wr_en, swap_pulse, fifo_choose, in_ready} !== 6'b000001 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset flags %b%b%b%b%b%b data %0d want 000001 0",
               out_valid, fifo_rd_en, fifo_wr_en, swap_pulse, fifo_choose, in_ready, out_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_obs();
    out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send_word(DW'(i), ok, cyc);
    in_valid = 1'b0;
    wait_out(4, ok);
    repeat (4) step();
    checks++;
    if (!ok || got_q.size() != 4) begin errors++; $display("FAIL mid_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i] !== DW'(i + 5)) begin errors++; $display("FAIL mid_order idx %0d got %0d want %0d", i, got_q[i], i + 5); end
    end
  endtask

  task automatic test_random();
    bit ok; int cyc; int fill;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    fill = (DEPTH - (acc_q.size() % DEPTH)) % DEPTH;
    for (int i = 0; i < fill; i++) send_word(DW'($urandom), ok, cyc);
    in_valid = 1'b0;
    wait_out(acc_q.size(), ok);
    repeat (6) step();
    checks++;
    if (!ok || got_q.size() != acc_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), acc_q.size());
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (got_q[i] !== acc_q[i]) begin errors++; $display("FAIL rand_order idx %0d got %0d want %0d", i, got_q[i], acc_q[i]); end
    end
    checks++;
    if (swap_at.size() != acc_q.size() / DEPTH) begin
      errors++; $display("FAIL rand_swaps got %0d want %0d", swap_at.size(), acc_q.size() / DEPTH);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_idle in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (bank_bad != 0 || wr_bad != 0) begin errors++; $display("FAIL rand_banks bank_bad %0d wr_bad %0d want 0 0", bank_bad, wr_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_stall();
    test_gap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
